ram_port_arbiter: RTL
=====================

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 SHALL have parameter NB_COL, default 4, meaning byte lanes per word.
REQ-002 SHALL have parameter COL_WIDTH, default 8, meaning bits per byte lane.
REQ-003 SHALL have parameter ADDR_WIDTH, default 10, meaning word-address width.
REQ-004 SHALL have parameter RAM_LATENCY, default 1, meaning RAM read latency in cycles; legal values are 1 and 2 only, and any other value is an elaboration error.
REQ-005 SHALL have ports as listed; W = NB_COL*COL_WIDTH; the clock is clk and reset is rst; one clock only; reset is asynchronous and active-high.
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  asynchronous active-high reset.
- mN_req  in  1  master N request, N = 0 or 1.
- mN_lock  in  1  master N holds port ownership past the current grant.
- mN_we  in  NB_COL  master N byte write enables; all-zero means read.
- mN_addr  in  ADDR_WIDTH  master N word address.
- mN_wdata  in  W  master N write data.
- mN_gnt  out  1  master N request accepted this cycle.
- mN_rvalid  out  1  master N read data valid.
- rdata  out  W  read data, shared by both masters.
- ram_en  out  1  RAM port enable.
- ram_we  out  NB_COL  RAM byte write enables.
- ram_addr  out  ADDR_WIDTH  RAM address.
- ram_din  out  W  RAM write data.
- ram_regce  out  1  RAM output register enable.
- ram_dout  in  W  RAM read data.

Function
REQ-006 SHALL keep an ownership FSM with states IDLE, OWN0 and OWN1.
REQ-007 SHALL arbitrate combinationally within a cycle: mN_gnt = mN_req AND (mN is selected).
REQ-008 SHALL select as follows when in IDLE:
- If only one master requests, select that master.
- If both request, select the master not granted most recently (round-robin pointer).
- The pointer favours m0 after reset.
REQ-009 SHALL select mN unconditionally in OWNN; the other master gets no grant even if it requests.
REQ-010 SHALL set the next state to OWNN when mN is granted with mN_lock=1, and to IDLE otherwise.
- This includes OWNN with mN_req=0: no grant is issued and the next state is IDLE.
REQ-011 SHALL update the round-robin pointer to N on every cycle mN is granted.
REQ-012 SHALL drive ram_en=1 in a grant cycle, with ram_addr, ram_we and ram_din taken from the granted master.
REQ-013 SHALL drive ram_en=0 and ram_we=0 when no grant is issued; ram_addr and ram_din are then don't-care but are driven to 0.
REQ-014 SHALL treat a grant with mN_we=0 as a read and a grant with mN_we≠0 as a write; writes produce no rvalid.
REQ-015 SHALL track reads in a RAM_LATENCY-deep shift pipeline of {valid, master id}, which advances every cycle.
REQ-016 SHALL assert mN_rvalid exactly RAM_LATENCY cycles after the grant cycle of mN's read, for one cycle, to the issuing master only.
REQ-017 SHALL drive rdata = ram_dout in every cycle; rdata is meaningful only when an rvalid is high.
REQ-018 SHALL drive ram_regce = 1 constantly when RAM_LATENCY=2, and 0 when RAM_LATENCY=1.
REQ-019 SHALL sustain back-to-back grants, one per cycle, with up to RAM_LATENCY reads in flight; m0_rvalid and m1_rvalid are never high in the same cycle.
REQ-020 SHALL require masters to hold req and its request fields stable until gnt; the arbiter does not check this.
REQ-021 SHALL produce read-first data for a read granted in the cycle after a write to the same address, i.e. the new data.

Reset
REQ-022 SHALL, while rst=1, force all of the following, asynchronously:
- FSM to IDLE.
- Pointer favouring m0.
- Read pipeline to empty.
- m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, ram_en, ram_we and ram_addr to 0.
REQ-023 SHALL discard reads in flight when reset is asserted mid-operation; no rvalid appears for them after rst deasserts.
REQ-024 SHALL accept a first grant in the first rising edge cycle after rst deasserts.

Verification
REQ-025 SHALL cover a single read: RAM_LATENCY=1, m0 reads addr 5 holding 0xDEADBEEF -> m0_gnt in cycle t, m0_rvalid in t+1 with rdata=0xDEADBEEF, m1_rvalid stays 0.
REQ-026 SHALL cover round-robin: both masters request continuously, no lock -> grants alternate m0, m1, m0, m1 starting with m0 after reset.
REQ-027 SHALL cover lock:
- Stimulus: m1 granted with m1_lock=1 for 3 cycles while m0 requests throughout.
- Response: m0_gnt=0 for those cycles; m0 is granted in the cycle after m1_lock drops.
REQ-028 SHALL cover write then read: m0 writes 0x11223344 with we=4'b0101 to addr 7 holding 0 -> a subsequent read of addr 7 returns 0x00220044, and the write cycle produces no rvalid.
REQ-029 SHALL cover latency 2: RAM_LATENCY=2, reads m0, m1, m0 granted back-to-back in t..t+2 -> rvalid m0 at t+2, m1 at t+3, m0 at t+4, with matching data.
REQ-030 SHALL cover reset mid-flight: rst asserted the cycle after a read grant -> no rvalid appears, and after release m1 alone requesting is granted immediately.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// ---------------------------------------------------------------------------
// ram_port_arbiter
//   Shares one byte-writable RAM port between two masters. Arbitration is
//   combinational within the cycle: round-robin when both request in IDLE, and
//   sticky ownership (OWN0/OWN1) while the granted master holds its lock.
//   Reads are tracked in a RAM_LATENCY-deep {valid, id} shift pipeline, so each
//   read returns an rvalid to its issuing master exactly RAM_LATENCY cycles
//   after its grant.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   mN_req/lock/we/addr/wdata master N request fields (N = 0, 1)
//   mN_gnt                    master N request accepted this cycle
//   mN_rvalid                 master N read data valid
//   rdata                     read data, shared, straight from ram_dout
//   ram_en/we/addr/din        RAM port command
//   ram_regce                 RAM output register enable (latency 2 only)
//   ram_dout                  RAM read data
// ---------------------------------------------------------------------------
module ram_port_arbiter #(
  parameter int NB_COL      = 4,
  parameter int COL_WIDTH   = 8,
  parameter int ADDR_WIDTH  = 10,
  parameter int RAM_LATENCY = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          m0_req,
  input  logic                          m0_lock,
  input  logic [NB_COL-1:0]             m0_we,
  input  logic [ADDR_WIDTH-1:0]         m0_addr,
  input  logic [NB_COL*COL_WIDTH-1:0]   m0_wdata,
  output logic                          m0_gnt,
  output logic                          m0_rvalid,
  input  logic                          m1_req,
  input  logic                          m1_lock,
  input  logic [NB_COL-1:0]             m1_we,
  input  logic [ADDR_WIDTH-1:0]         m1_addr,
  input  logic [NB_COL*COL_WIDTH-1:0]   m1_wdata,
  output logic                          m1_gnt,
  output logic                          m1_rvalid,
  output logic [NB_COL*COL_WIDTH-1:0]   rdata,
  output logic                          ram_en,
  output logic [NB_COL-1:0]             ram_we,
  output logic [ADDR_WIDTH-1:0]         ram_addr,
  output logic [NB_COL*COL_WIDTH-1:0]   ram_din,
  output logic                          ram_regce,
  input  logic [NB_COL*COL_WIDTH-1:0]   ram_dout
);

  localparam int W = NB_COL * COL_WIDTH;

  generate
    if (RAM_LATENCY != 1 && RAM_LATENCY != 2) begin : g_bad_latency
      $error("ram_port_arbiter: RAM_LATENCY must be 1 or 2");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t state_reg, state_next;
  logic   last_reg;          // id of the most recently granted master
  logic   sel1;              // 1 = m1 selected this cycle
  logic   gnt0, gnt1;
  logic   read_issue;

  logic [RAM_LATENCY-1:0] pipe_valid_reg, pipe_valid_next;
  logic [RAM_LATENCY-1:0] pipe_id_reg, pipe_id_next;

  // Selection: owner wins outright; otherwise round-robin on contention.
  always_comb begin
    sel1 = 1'b0;
    case (state_reg)
      OWN0:    sel1 = 1'b0;
      OWN1:    sel1 = 1'b1;
      default: sel1 = (m0_req && m1_req) ? ~last_reg : m1_req;
    endcase
  end

  // Grants are combinational but must read as 0 while reset is held.
  assign gnt0 = m0_req & ~sel1 & ~rst;
  assign gnt1 = m1_req &  sel1 & ~rst;

  assign m0_gnt = gnt0;
  assign m1_gnt = gnt1;

  // Ownership persists only through a locked grant; an owner that stops
  // requesting releases the port.
  always_comb begin
    state_next = IDLE;
    if (gnt0 && m0_lock)
      state_next = OWN0;
    else if (gnt1 && m1_lock)
      state_next = OWN1;
  end

  // RAM command mux; idle cycles drive zeros.
  assign ram_en   = gnt0 | gnt1;
  assign ram_we   = gnt0 ? m0_we   : (gnt1 ? m1_we   : '0);
  assign ram_addr = gnt0 ? m0_addr : (gnt1 ? m1_addr : '0);

  genvar gi;
  generate
    for (gi = 0; gi < NB_COL; gi++) begin : g_din_lane
      assign ram_din[gi*COL_WIDTH +: COL_WIDTH] =
        gnt0 ? m0_wdata[gi*COL_WIDTH +: COL_WIDTH] :
        (gnt1 ? m1_wdata[gi*COL_WIDTH +: COL_WIDTH] : '0);
    end
  endgenerate

  assign read_issue = (gnt0 && (m0_we == '0)) || (gnt1 && (m1_we == '0));

  // Read tracking pipeline: stage 0 captures this cycle's read grant, the
  // last stage lines up with the cycle the RAM presents its data.
  always_comb begin
    pipe_valid_next    = '0;
    pipe_id_next       = '0;
    pipe_valid_next[0] = read_issue;
    pipe_id_next[0]    = gnt1;
    for (int i = 1; i < RAM_LATENCY; i++) begin
      pipe_valid_next[i] = pipe_valid_reg[i-1];
      pipe_id_next[i]    = pipe_id_reg[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      last_reg       <= 1'b1;   // pretend m1 went last so m0 wins first
      pipe_valid_reg <= '0;
      pipe_id_reg    <= '0;
    end else begin
      state_reg      <= state_next;
      pipe_valid_reg <= pipe_valid_next;
      pipe_id_reg    <= pipe_id_next;
      if (gnt0)
        last_reg <= 1'b0;
      else if (gnt1)
        last_reg <= 1'b1;
    end
  end

  assign m0_rvalid = pipe_valid_reg[RAM_LATENCY-1] & ~pipe_id_reg[RAM_LATENCY-1];
  assign m1_rvalid = pipe_valid_reg[RAM_LATENCY-1] &  pipe_id_reg[RAM_LATENCY-1];

  assign rdata     = ram_dout;
  assign ram_regce = (RAM_LATENCY == 2);

  logic [W-1:0] unused_width_tie;
  assign unused_width_tie = '0;

endmodule
